// File: rtl/down_count_pkg.sv
// Shared constants for the loadable down-counter/timer.
// State encoding and default width used by down_count_timer and down_cnt_core.
package down_count_pkg;

   localparam int unsigned DEFAULT_WIDTH = 2;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t RUN    = 2'd1;
   localparam state_t EXPIRE = 2'd2;

endpackage

// File: rtl/down_cnt_core.sv
// WIDTH-bit count register with synchronous clear, load and a decrement that
// never goes below zero. Reports its value and whether it currently equals one.
module down_cnt_core
   import down_count_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             is_one
);

   logic [WIDTH-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (dec && (value_q != '0)) begin
         value_d = value_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value  = value_q;
   assign is_one = (value_q == WIDTH'(1));

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// Define DOWN_COUNT_TIMER_AUTO_RELOAD_EN to restart from the reload value after expiry.
module down_count_timer
   import down_count_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] CNT,
   output logic             tc,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] core_val;
   logic             core_load;
   logic             core_dec;
   logic             cnt_is_one;
   logic             reload_fire;

`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
   assign reload_fire = (state_q == EXPIRE) && (reload_q != '0) && !load;
`else
   // Single-shot build: reload register is kept for visibility but never read back.
   logic unused_reload;
   assign reload_fire   = 1'b0;
   assign unused_reload = ^reload_q;
`endif

   // An external load always beats the decrement and any auto-reload.
   assign core_load = load | reload_fire;
   assign core_val  = load ? load_val : reload_q;
   assign core_dec  = (state_q == RUN) && en && !load;
   assign reload_d  = load ? load_val : reload_q;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (load_val != '0) ? RUN : EXPIRE;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     state_d = (en && cnt_is_one) ? EXPIRE : RUN;
            EXPIRE:  state_d = reload_fire ? RUN : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         reload_q <= '0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
      end
   end

   down_cnt_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (core_load),
      .load_val(core_val),
      .dec     (core_dec),
      .value   (CNT),
      .is_one  (cnt_is_one)
   );

   assign tc   = (state_q == EXPIRE);
   assign busy = (state_q == RUN);

   // Count is nonzero exactly while running.
   a_run_nonzero : assert property (@(posedge clk) disable iff (rst)
      (state_q == RUN) |-> (CNT != '0));
   a_idle_zero : assert property (@(posedge clk) disable iff (rst)
      (state_q != RUN) |-> (CNT == '0));
   a_state_legal : assert property (@(posedge clk) disable iff (rst)
      (state_q != 2'd3));

endmodule

// File: tb/tb_down_count_timer.sv
// Self-checking bench for down_count_timer: directed scenarios plus randomized
// traffic against a behavioural countdown model.
module tb_down_count_timer;

   localparam int unsigned W = 2;

`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         en = 1'b0;
   logic [W-1:0] CNT;
   logic         tc;
   logic         busy;

   int tests_run = 0;
   int failures  = 0;

   // Behavioural model: remaining ticks, whether counting, pending expiry pulse.
   int m_cnt;
   int m_reload;
   bit m_active;
   bit m_tc;

   always #5 clk = ~clk;

   down_count_timer #(
      .WIDTH(W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .load_val(load_val),
      .en      (en),
      .CNT     (CNT),
      .tc      (tc),
      .busy    (busy)
   );

   task automatic model_step(input bit r, input bit l, input int lv, input bit e);
      if (r) begin
         m_cnt = 0; m_reload = 0; m_active = 0; m_tc = 0;
      end else if (l) begin
         m_cnt    = lv;
         m_reload = lv;
         m_active = (lv != 0);
         m_tc     = (lv == 0);
      end else if (m_tc) begin
         m_tc = 0;
         if (AUTO && m_reload != 0) begin
            m_cnt    = m_reload;
            m_active = 1;
         end else begin
            m_active = 0;
         end
      end else if (m_active && e) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_active = 0;
            m_tc     = 1;
         end
      end
   endtask

   // Apply inputs for one clock, advance the model, then settle past the edge.
   task automatic cyc(input bit r, input bit l, input int lv, input bit e);
      rst = r; load = l; load_val = W'(lv); en = e;
      @(posedge clk);
      model_step(r, l, lv, e);
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0);
      cyc(1, 1, 3, 1);
      tests_run++;
      if ({CNT, busy, tc} !== {W'(0), 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset: CNT=%0d busy=%0b tc=%0b, want 0 0 0", CNT, busy, tc);
      end
      cyc(0, 0, 0, 1);
      tests_run++;
      if ({CNT, busy, tc} !== {W'(0), 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_idle_en: CNT=%0d busy=%0b tc=%0b, want 0 0 0", CNT, busy, tc);
      end
   endtask

   task automatic test_basic_count();
      int exp_cnt[5]  = '{3, 2, 1, 0, 0};
      bit exp_busy[5] = '{1, 1, 1, 0, 0};
      bit exp_tc[5]   = '{0, 0, 0, 1, 0};
      for (int i = 0; i < 5; i++) begin
         if (i == 0) cyc(0, 1, 3, 0);
         else        cyc(0, 0, 0, 1);
         tests_run++;
         if ({CNT, busy, tc} !== {W'(exp_cnt[i]), exp_busy[i], exp_tc[i]}) begin
            failures++;
            $display("FAIL basic[%0d]: CNT=%0d busy=%0b tc=%0b, want %0d %0b %0b",
                     i, CNT, busy, tc, exp_cnt[i], exp_busy[i], exp_tc[i]);
         end
      end
   endtask

   task automatic test_pause();
      bit en_seq[5]  = '{1, 0, 0, 1, 1};
      int exp_cnt[5] = '{2, 2, 2, 1, 0};
      int tc_seen = 0;
      cyc(0, 1, 3, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, en_seq[i]);
         tc_seen += int'(tc);
         tests_run++;
         if ({CNT, tc} !== {W'(exp_cnt[i]), (i == 4)}) begin
            failures++;
            $display("FAIL pause[%0d]: CNT=%0d tc=%0b, want %0d %0b",
                     i, CNT, tc, exp_cnt[i], (i == 4));
         end
      end
      cyc(0, 0, 0, 0);
      tc_seen += int'(tc);
      tests_run++;
      if (tc_seen !== 1) begin
         failures++;
         $display("FAIL pause_tc_count: saw %0d pulses, want 1", tc_seen);
      end
   endtask

   task automatic test_reload_override();
      cyc(0, 1, 2, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 3, 1);
      tests_run++;
      if ({CNT, busy, tc} !== {W'(3), 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL override_load: CNT=%0d busy=%0b tc=%0b, want 3 1 0", CNT, busy, tc);
      end
      cyc(0, 0, 0, 1);
      tests_run++;
      if ({CNT, tc} !== {W'(2), 1'b0}) begin
         failures++;
         $display("FAIL override_resume: CNT=%0d tc=%0b, want 2 0", CNT, tc);
      end
      cyc(1, 0, 0, 0);
   endtask

   task automatic test_rst_mid_run();
      cyc(0, 1, 3, 0);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      tests_run++;
      if ({CNT, busy, tc} !== {W'(0), 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rst_mid_run: CNT=%0d busy=%0b tc=%0b, want 0 0 0", CNT, busy, tc);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1);
         tests_run++;
         if ({CNT, busy, tc} !== {W'(0), 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_then_en[%0d]: CNT=%0d busy=%0b tc=%0b, want 0 0 0",
                     i, CNT, busy, tc);
         end
      end
   endtask

   task automatic test_load_zero();
      cyc(0, 1, 0, 1);
      tests_run++;
      if ({CNT, busy, tc} !== {W'(0), 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL load_zero: CNT=%0d busy=%0b tc=%0b, want 0 0 1", CNT, busy, tc);
      end
      cyc(0, 0, 0, 1);
      tests_run++;
      if ({CNT, busy, tc} !== {W'(0), 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL load_zero_after: CNT=%0d busy=%0b tc=%0b, want 0 0 0", CNT, busy, tc);
      end
   endtask

   task automatic test_auto_reload();
      int exp_cnt[9] = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
      int tc_seen = 0;
      cyc(0, 1, 2, 1);
      tc_seen += int'(tc);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) begin
            cyc(0, 0, 0, 1);
            tc_seen += int'(tc);
         end
         if (AUTO || i < 3) begin
            tests_run++;
            if (CNT !== W'(exp_cnt[i])) begin
               failures++;
               $display("FAIL auto[%0d]: CNT=%0d, want %0d", i, CNT, exp_cnt[i]);
            end
         end
      end
      tests_run++;
      if (tc_seen !== (AUTO ? 3 : 1)) begin
         failures++;
         $display("FAIL auto_tc_count: saw %0d pulses, want %0d", tc_seen, AUTO ? 3 : 1);
      end
      cyc(1, 0, 0, 0);
   endtask

   task automatic test_random();
      bit r, l, e;
      int lv;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 31) == 0);
         l  = ($urandom_range(0, 5) == 0);
         e  = $urandom_range(0, 1) == 1;
         lv = int'($urandom_range(0, (1 << W) - 1));
         cyc(r, l, lv, e);
         tests_run++;
         if ({CNT, busy, tc} !== {W'(m_cnt), m_active, m_tc}) begin
            failures++;
            $display("FAIL random[%0d]: CNT=%0d busy=%0b tc=%0b, want %0d %0b %0b",
                     i, CNT, busy, tc, m_cnt, m_active, m_tc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_count();
      test_pause();
      test_reload_override();
      test_rst_mid_run();
      test_load_zero();
      test_auto_reload();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- Loadable down-counter/timer; the counting-down counterpart of the team's 2-bit up-counter.
- Loads a start value, decrements on each enabled cycle, and flags expiry with a one-cycle terminal-count pulse.
- Used as the timeout/interval source alongside the up-counter in the same clock domain.

Parameters:
- WIDTH, 2, counter width in bits (legal range 1..16).

Ports:
- clk  input  1  system clock; all flops update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  capture load_val and start counting.
- load_val  input  WIDTH  start value.
- en  input  1  count enable; low pauses the count.
- CNT  output  WIDTH  current count value.
- tc  output  1  terminal count; one-cycle pulse on expiry.
- busy  output  1  high while in RUN.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: CNT=0, tc=0, busy=0, state=IDLE, reload register=0.
- Priority order (highest first): rst, load, expiry/count.
- States:
  - IDLE: CNT holds; en ignored.
  - RUN: decrementing.
  - EXPIRE: one cycle; tc=1.
- load in any state:
  - Next edge sets CNT=load_val and reload register=load_val.
  - Next state is RUN if load_val!=0.
  - If load_val==0, next state is EXPIRE (CNT=0, tc=1 in that cycle).
- RUN, en=1:
  - CNT decrements by 1 each edge.
  - When CNT==1, next edge gives CNT=0 and state EXPIRE.
- RUN, en=0: CNT and state hold.
- EXPIRE:
  - tc=1 for exactly this cycle, independent of en.
  - Next state is IDLE; CNT stays 0.
- Outputs: tc is high only in EXPIRE. busy is high only in RUN. Both are decoded from registered state, so they are glitch-free.
- Latency: with load_val=N at edge k and en held high afterwards:
  - CNT=N after edge k.
  - tc=1 in the cycle after edge k+N.
  - busy=1 for N cycles.
- Wrap-around: none. CNT never decrements below 0. CNT==0 with en=1 in IDLE gives no change and no tc.
- load in the same cycle as the 1→0 decrement: load wins, no EXPIRE, no tc.
- load during EXPIRE: tc still pulses in that cycle; next state is per load_val.
- rst mid-RUN or mid-EXPIRE: returns to reset values at the next edge, no tc.
- Arithmetic: decrement is modulo-free WIDTH-bit subtraction, guarded by state so it never underflows.

Optional Feature:
- Macro: DOWN_COUNT_TIMER_AUTO_RELOAD_EN.
- Defined: EXPIRE transitions to RUN with CNT=reload register if the reload register is nonzero, otherwise to IDLE. With en high, the period is N+1 clocks and tc is periodic.
- Undefined: EXPIRE always transitions to IDLE (single-shot); the reload register is still loaded but is unused.

Decomposition:
- Shared package down_count_pkg:
  - State enumeration: IDLE=2'd0, RUN=2'd1, EXPIRE=2'd2.
  - Constant for the default width (2).
- One sub-module, down_cnt_core:
  - WIDTH-bit register with synchronous clear, load, and guarded decrement.
  - Outputs its value and an is_one flag.
- The top-level block holds the FSM, reload register, and output decode.

Test Plan:
- WIDTH=2; rst=1 for 2 cycles, then load=1 with load_val=3, then en=1 → CNT 3,2,1,0; busy=1 during 3,2,1; tc=1 only in the CNT=0 cycle; then IDLE with CNT=0.
- load 3, en toggles 1,0,0,1,1 → CNT 3,2,2,2,1,0; tc asserts once, in the CNT=0 cycle.
- load 2; at CNT=1 assert load with load_val=3 → no tc; CNT=3 next cycle and counting resumes.
- load 3; after one decrement assert rst → next cycle CNT=0, busy=0, tc=0; en alone afterwards gives no change.
- load with load_val=0 → next cycle tc=1, busy=0, CNT=0; the following cycle tc=0 and state is IDLE.
- DOWN_COUNT_TIMER_AUTO_RELOAD_EN defined; load 2, en held high → CNT 2,1,0,2,1,0…; tc every 3 cycles. With the macro undefined, tc fires once.
